io_debounce: RTL

IO_DEBOUNCE -- requirements
Module: io_debounce

---
 rtl/io_debounce.sv | 88 ++++++++
 1 files changed

// File: rtl/io_debounce.sv
// Debounces 18 slide switches and 4 active-low keys. Each bit needs
// STABLE_TICKS consecutive disagreeing prescaler ticks before its level changes.
module io_debounce #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [17:0] i_sw,
  input  logic [3:0]  i_key,
  output logic [31:0] o_ph_sw,
  output logic [31:0] o_ph_button,
  output logic [3:0]  o_btn_press,
  output logic        o_tick
);

  localparam int NB = 22;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]    CNT_LAST = 8'(STABLE_TICKS - 1);

  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] level;
  logic [NB-1:0] level_next;
  logic [7:0]    stab_cnt      [NB];
  logic [7:0]    stab_cnt_next [NB];
  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_cnt_next;
  logic          tick_q;
  logic [3:0]    press_q;

  always_comb begin
    div_cnt_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
  end

  // Keys are inverted ahead of the first flop so everything downstream is active-high.
  // tick_q is registered one count early so it is high while div_cnt == TICK_DIV-1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1   <= '0;
      sync2   <= '0;
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync1   <= {~i_key, i_sw};
      sync2   <= sync1;
      div_cnt <= div_cnt_next;
      tick_q  <= (div_cnt_next == DIV_LAST);
    end
  end

  always_comb begin
    level_next = level;
    for (int i = 0; i < NB; i++) begin
      stab_cnt_next[i] = stab_cnt[i];
      if (sync2[i] == level[i]) begin
        stab_cnt_next[i] = '0;
      end else if (tick_q) begin
        if (stab_cnt[i] == CNT_LAST) begin
          level_next[i]    = sync2[i];
          stab_cnt_next[i] = '0;
        end else begin
          stab_cnt_next[i] = stab_cnt[i] + 8'd1;
        end
      end
    end
  end

  // The press pulse lines up with the first cycle the new level is visible.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level   <= '0;
      press_q <= '0;
      for (int i = 0; i < NB; i++) stab_cnt[i] <= '0;
    end else begin
      level   <= level_next;
      press_q <= level_next[21:18] & ~level[21:18];
      for (int i = 0; i < NB; i++) stab_cnt[i] <= stab_cnt_next[i];
    end
  end

  assign o_ph_sw     = {14'b0, level[17:0]};
  assign o_ph_button = {28'b0, level[21:18]};
  assign o_btn_press = press_q;
  assign o_tick      = tick_q;

endmodule
